// File: rtl/acq_search_engine_pkg.sv
// acq_search_engine_pkg: shared code-phase widths, FSM encodings and width helpers for the acquisition search engine
package acq_search_engine_pkg;

    // Code phase counts half-chips over one 1023-chip C/A period: 0..2045.
    localparam int CS_WIDTH = 11;
    localparam logic [CS_WIDTH-1:0] MAX_CODE_SHIFT = 11'd2045;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SQUARE = 2'd1,
        ST_DONE   = 2'd2
    } acq_state_e;

    // Enough bits that ACC_LEN worst-case terms can never overflow.
    function automatic int acc_width(input int corr_width, input int acc_len);
        return corr_width + $clog2(acc_len) + 1;
    endfunction

    // Sum of two full-width squares needs one extra bit.
    function automatic int i2q2_width(input int corr_width, input int acc_len);
        return 2 * acc_width(corr_width, acc_len) + 1;
    endfunction

endpackage

// File: rtl/acq_squarer.sv
// acq_squarer: registered signed-input square, one cycle latency
//   clk, rst_n : clock, asynchronous active-low reset
//   sq_in      : signed W-bit operand
//   sq_out     : unsigned 2W-bit square of the previous cycle's operand
module acq_squarer #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] sq_in,
    output logic [2*W-1:0]      sq_out
);

    logic signed [2*W-1:0] in_ext;
    logic [2*W-1:0]        sq_d, sq_q;

    // Extend before multiplying so the product is formed at full width;
    // even (-2^(W-1))^2 fits in 2W unsigned bits.
    always_comb begin
        in_ext = {{W{sq_in[W-1]}}, sq_in};
        sq_d   = in_ext * in_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sq_q <= '0;
        else        sq_q <= sq_d;
    end

    assign sq_out = sq_q;

endmodule

// File: rtl/acq_search_engine.sv
// acq_search_engine: code-phase slewing plus early/prompt/late I/Q accumulation and I^2+Q^2 power computation
//   clk, global_reset_n          : clock, asynchronous active-low reset
//   feed_reset                   : restart accumulation (discards partial sums, no complete strobe)
//   sample_valid, corr_i, corr_q : correlator sample, terms packed {late, prompt, early}
//   seek_en, code_shift          : slew code_phase toward code_shift, one step per sample
//   code_phase, seeking, target_reached : slew status
//   accumulation_complete        : one-cycle strobe after the last sample of an accumulation
//   i2q2_valid, i2q2_early/prompt/late : power of the last accumulation
module acq_search_engine
    import acq_search_engine_pkg::*;
#(
    parameter  int ACC_LEN    = 16368,
    parameter  int CORR_WIDTH = 3,
    localparam int ACC_WIDTH  = acc_width(CORR_WIDTH, ACC_LEN),
    localparam int I2Q2_WIDTH = i2q2_width(CORR_WIDTH, ACC_LEN)
) (
    input  logic                    clk,
    input  logic                    global_reset_n,
    input  logic                    feed_reset,
    input  logic                    sample_valid,
    input  logic [3*CORR_WIDTH-1:0] corr_i,
    input  logic [3*CORR_WIDTH-1:0] corr_q,
    input  logic                    seek_en,
    input  logic [CS_WIDTH-1:0]     code_shift,
    output logic [CS_WIDTH-1:0]     code_phase,
    output logic                    seeking,
    output logic                    target_reached,
    output logic                    accumulation_complete,
    output logic                    i2q2_valid,
    output logic [I2Q2_WIDTH-1:0]   i2q2_early,
    output logic [I2Q2_WIDTH-1:0]   i2q2_prompt,
    output logic [I2Q2_WIDTH-1:0]   i2q2_late
);

    localparam int CNT_W = $clog2(ACC_LEN);
    localparam int EXT_W = ACC_WIDTH - CORR_WIDTH;

    logic [CS_WIDTH-1:0]          phase_d, phase_q;
    logic                         seeking_d, seeking_q, reached_d, reached_q;
    logic [CNT_W-1:0]             cnt_d, cnt_q;
    // Index order everywhere: 0 Ie, 1 Qe, 2 Ip, 3 Qp, 4 Il, 5 Ql
    logic [CORR_WIDTH-1:0]        raw[6];
    logic signed [ACC_WIDTH-1:0]  term[6];
    logic signed [ACC_WIDTH-1:0]  acc_d[6], acc_q[6], hold_d[6], hold_q[6];
    logic                         last_sample, complete_d, complete_q;
    acq_state_e                   state_d, state_q;
    logic [2:0]                   idx_d, idx_q;
    logic [1:0]                   sel_d, sel_q;
    logic                         sq_vld_d, sq_vld_q, valid_d, valid_q;
    logic [I2Q2_WIDTH-1:0]        sum_d[3], sum_q[3];
    logic signed [ACC_WIDTH-1:0]  sq_in;
    logic [2*ACC_WIDTH-1:0]       sq_out;

    always_comb begin
        phase_d = phase_q;
        if (seek_en && sample_valid && phase_q != code_shift)
            phase_d = (phase_q == MAX_CODE_SHIFT) ? '0 : phase_q + CS_WIDTH'(1);
        seeking_d = seek_en && (phase_d != code_shift);
        reached_d = (phase_d == code_shift);
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            raw[k]  = (k % 2 == 1) ? corr_q[(k/2)*CORR_WIDTH +: CORR_WIDTH]
                                   : corr_i[(k/2)*CORR_WIDTH +: CORR_WIDTH];
            term[k] = {{EXT_W{raw[k][CORR_WIDTH-1]}}, raw[k]};
        end
        last_sample = sample_valid && (cnt_q == CNT_W'(ACC_LEN - 1));
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        hold_d     = hold_q;
        complete_d = 1'b0;
        // feed_reset outranks a coinciding final sample: the partial sum is dropped.
        if (feed_reset) begin
            cnt_d = '0;
            for (int k = 0; k < 6; k++) acc_d[k] = '0;
        end else if (sample_valid) begin
            for (int k = 0; k < 6; k++) begin
                acc_d[k] = last_sample ? '0 : acc_q[k] + term[k];
                if (last_sample) hold_d[k] = acc_q[k] + term[k];
            end
            cnt_d      = last_sample ? '0 : cnt_q + CNT_W'(1);
            complete_d = last_sample;
        end
    end

    // SQUARE issues hold[idx] for idx 0..5 and uses idx 6 as the drain cycle
    // for the last squarer result; sq_vld/sel tag each squarer output.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        sum_d    = sum_q;
        sq_vld_d = 1'b0;
        sel_d    = idx_q[2:1];
        if (complete_q) begin
            state_d = ST_SQUARE;
            idx_d   = '0;
            valid_d = 1'b0;
            for (int k = 0; k < 3; k++) sum_d[k] = '0;
        end else begin
            if (sq_vld_q) sum_d[sel_q] = sum_q[sel_q] + {1'b0, sq_out};
            if (state_q == ST_SQUARE) begin
                sq_vld_d = (idx_q < 3'd6);
                idx_d    = idx_q + 3'd1;
                if (idx_q == 3'd6) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign sq_in = (idx_q < 3'd6) ? hold_q[idx_q] : '0;

    acq_squarer #(.W(ACC_WIDTH)) u_squarer (
        .clk    (clk),
        .rst_n  (global_reset_n),
        .sq_in  (sq_in),
        .sq_out (sq_out)
    );

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            phase_q    <= '0;
            seeking_q  <= 1'b0;
            reached_q  <= 1'b0;
            cnt_q      <= '0;
            for (int k = 0; k < 6; k++) begin
                acc_q[k]  <= '0;
                hold_q[k] <= '0;
            end
            complete_q <= 1'b0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sel_q      <= '0;
            sq_vld_q   <= 1'b0;
            valid_q    <= 1'b0;
            for (int k = 0; k < 3; k++) sum_q[k] <= '0;
        end else begin
            phase_q    <= phase_d;
            seeking_q  <= seeking_d;
            reached_q  <= reached_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            complete_q <= complete_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            sq_vld_q   <= sq_vld_d;
            valid_q    <= valid_d;
            sum_q      <= sum_d;
        end
    end

    assign code_phase            = phase_q;
    assign seeking               = seeking_q;
    // While in reset the phase is zero, so the match is evaluated against that.
    assign target_reached        = global_reset_n ? reached_q : (code_shift == '0);
    assign accumulation_complete = complete_q;
    assign i2q2_valid            = valid_q;
    assign i2q2_early            = sum_q[0];
    assign i2q2_prompt           = sum_q[1];
    assign i2q2_late             = sum_q[2];

endmodule

// File: tb/tb_acq_search_engine.sv
// tb_acq_search_engine: self-checking bench for acq_search_engine with ACC_LEN=16
module tb_acq_search_engine;
    import acq_search_engine_pkg::*;

    localparam int ACC_LEN = 16;
    localparam int CW      = 3;
    localparam int IW      = 2 * (CW + 4 + 1) + 1;

    logic              clk = 1'b0;
    logic              global_reset_n, feed_reset, sample_valid, seek_en;
    logic [3*CW-1:0]   corr_i, corr_q;
    logic [CS_WIDTH-1:0] code_shift, code_phase;
    logic              seeking, target_reached, accumulation_complete, i2q2_valid;
    logic [IW-1:0]     i2q2_early, i2q2_prompt, i2q2_late;

    always #5 clk = ~clk;

    acq_search_engine #(.ACC_LEN(ACC_LEN), .CORR_WIDTH(CW)) dut (
        .clk(clk), .global_reset_n(global_reset_n), .feed_reset(feed_reset),
        .sample_valid(sample_valid), .corr_i(corr_i), .corr_q(corr_q),
        .seek_en(seek_en), .code_shift(code_shift), .code_phase(code_phase),
        .seeking(seeking), .target_reached(target_reached),
        .accumulation_complete(accumulation_complete), .i2q2_valid(i2q2_valid),
        .i2q2_early(i2q2_early), .i2q2_prompt(i2q2_prompt), .i2q2_late(i2q2_late)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ie, qe, ip, qp, il, ql;
        int exp_e, exp_p, exp_l;
    } vec_t;
    typedef struct { longint e, p, l; } res_t;

    vec_t vecs[4];
    res_t sb[$];
    res_t got;
    logic vprev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int ie, qe, ip, qp, il, ql, input logic fr);
        sample_valid = 1'b1;
        feed_reset   = fr;
        corr_i = {3'(il), 3'(ip), 3'(ie)};
        corr_q = {3'(ql), 3'(qp), 3'(qe)};
        step();
        sample_valid = 1'b0;
        feed_reset   = 1'b0;
    endtask

    task automatic feed(input vec_t v, input int n);
        for (int i = 0; i < n; i++) sample(v.ie, v.qe, v.ip, v.qp, v.il, v.ql, 1'b0);
    endtask

    task automatic push(input vec_t v);
        res_t r;
        r.e = v.exp_e; r.p = v.exp_p; r.l = v.exp_l;
        sb.push_back(r);
    endtask

    // Scoreboard: each new i2q2_valid rise consumes the oldest expected result.
    always @(negedge clk) begin
        if (i2q2_valid && !vprev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got early=%0d with nothing expected", i2q2_early);
            end else begin
                got = sb.pop_front();
                chk("i2q2_early", i2q2_early, got.e);
                chk("i2q2_prompt", i2q2_prompt, got.p);
                chk("i2q2_late", i2q2_late, got.l);
            end
        end
        vprev <= i2q2_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[6];
        int v[6];
        res_t r;
        vecs[0] = '{3, -4, 0, 0, 0, 0, 6400, 0, 0};
        vecs[1] = '{0, 0, -4, -4, 1, 2, 0, 8192, 1280};
        vecs[2] = '{3, 3, 3, -4, -4, -4, 4608, 6400, 8192};
        vecs[3] = '{-1, 1, 2, 0, 0, -3, 512, 1024, 2304};

        global_reset_n = 1'b0;
        feed_reset = 1'b0; sample_valid = 1'b0; seek_en = 1'b0;
        corr_i = '0; corr_q = '0; code_shift = '0;
        #12;
        chk("rst_code_phase", code_phase, 0);
        chk("rst_seeking", seeking, 0);
        chk("rst_target_reached_shift0", target_reached, 1);
        chk("rst_complete", accumulation_complete, 0);
        chk("rst_valid", i2q2_valid, 0);
        code_shift = 11'd3;
        #1;
        chk("rst_target_reached_shift3", target_reached, 0);
        code_shift = '0;
        @(posedge clk); #1;
        global_reset_n = 1'b1;
        step();

        // Seek 0 -> 5; feed_reset held so no accumulation completes meanwhile.
        feed_reset = 1'b1; seek_en = 1'b1; code_shift = 11'd5;
        step();
        chk("seek_no_sample_no_move", code_phase, 0);
        sample_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("seek_phase", code_phase, (k < 5) ? k : 5);
            chk("seek_seeking", seeking, (k < 5) ? 1 : 0);
            chk("seek_reached", target_reached, (k >= 5) ? 1 : 0);
        end
        code_shift = MAX_CODE_SHIFT;
        for (int i = 0; i < 2100 && code_phase != MAX_CODE_SHIFT; i++) step();
        chk("wrap_reach_max", code_phase, MAX_CODE_SHIFT);
        chk("wrap_reached_at_max", target_reached, 1);
        code_shift = 11'd1;
        step();
        chk("wrap_phase_zero", code_phase, 0);
        chk("wrap_not_reached", target_reached, 0);
        step();
        chk("wrap_phase_one", code_phase, 1);
        chk("wrap_reached", target_reached, 1);
        chk("wrap_seeking_off", seeking, 0);
        seek_en = 1'b0; sample_valid = 1'b0; feed_reset = 1'b0;
        step();

        // Table of constant-term accumulations with full timing checks.
        for (int r = 0; r < 4; r++) begin
            feed(vecs[r], ACC_LEN - 1);
            chk("no_early_complete", accumulation_complete, 0);
            feed(vecs[r], 1);
            chk("complete_at_T", accumulation_complete, 1);
            push(vecs[r]);
            for (int k = 1; k <= 8; k++) begin
                step();
                chk("valid_timing", i2q2_valid, (k == 8) ? 1 : 0);
            end
            chk("complete_one_cycle", accumulation_complete, 0);
        end

        // Randomised accumulation against a running-sum model.
        for (int k = 0; k < 6; k++) acc[k] = 0;
        for (int i = 0; i < ACC_LEN; i++) begin
            for (int k = 0; k < 6; k++) begin
                v[k] = int'($urandom_range(0, 7)) - 4;
                acc[k] += v[k];
            end
            sample(v[0], v[1], v[2], v[3], v[4], v[5], 1'b0);
        end
        r.e = acc[0]*acc[0] + acc[1]*acc[1];
        r.p = acc[2]*acc[2] + acc[3]*acc[3];
        r.l = acc[4]*acc[4] + acc[5]*acc[5];
        sb.push_back(r);
        for (int k = 0; k < 9; k++) step();
        chk("random_valid", i2q2_valid, 1);

        // feed_reset on the final sample suppresses the completion.
        feed(vecs[0], ACC_LEN - 1);
        sample(3, -4, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("collision_no_complete", accumulation_complete, 0);
            step();
        end
        chk("collision_valid_held", i2q2_valid, 1);
        feed(vecs[1], ACC_LEN);
        chk("collision_next_complete", accumulation_complete, 1);
        push(vecs[1]);
        for (int k = 0; k < 9; k++) step();
        chk("collision_next_valid", i2q2_valid, 1);

        // Asynchronous reset at T+4, mid-SQUARE.
        feed(vecs[2], ACC_LEN);
        chk("pre_reset_complete", accumulation_complete, 1);
        for (int k = 0; k < 4; k++) step();
        global_reset_n = 1'b0;
        #2;
        chk("midsq_rst_valid", i2q2_valid, 0);
        chk("midsq_rst_early", i2q2_early, 0);
        chk("midsq_rst_prompt", i2q2_prompt, 0);
        chk("midsq_rst_late", i2q2_late, 0);
        chk("midsq_rst_complete", accumulation_complete, 0);
        @(posedge clk); #1;
        global_reset_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("post_rst_valid_low", i2q2_valid, 0);
        chk("post_rst_early_zero", i2q2_early, 0);
        feed(vecs[3], ACC_LEN - 1);
        chk("post_rst_no_early_complete", accumulation_complete, 0);
        feed(vecs[3], 1);
        chk("post_rst_complete", accumulation_complete, 1);
        push(vecs[3]);
        for (int k = 0; k < 9; k++) step();
        chk("post_rst_valid", i2q2_valid, 1);

        step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acq_search_engine.md
ACQ_SEARCH_ENGINE -- requirements
Module: acq_search_engine

Interface
REQ-001 SHALL have parameter ACC_LEN, default 16368: samples per accumulation; legal range 16 or more.
REQ-002 SHALL have parameter CORR_WIDTH, default 3: signed width of each per-sample correlator term.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port global_reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port feed_reset, input, 1: start of data feed period; restarts accumulation.
REQ-006 SHALL have port sample_valid, input, 1: one correlator sample is present this cycle.
REQ-007 SHALL have port corr_i, input, 3*CORR_WIDTH: signed I terms packed {late, prompt, early}.
REQ-008 SHALL have port corr_q, input, 3*CORR_WIDTH: signed Q terms packed {late, prompt, early}.
REQ-009 SHALL have port seek_en, input, 1: slew the code phase toward code_shift.
REQ-010 SHALL have port code_shift, input, CS width: target code phase.
REQ-011 SHALL have port code_phase, output, CS width: current code phase.
REQ-012 SHALL have port seeking, output, 1: slewing is in progress.
REQ-013 SHALL have port target_reached, output, 1: code_phase equals code_shift.
REQ-014 SHALL have port accumulation_complete, output, 1: one-cycle strobe marking the end of an accumulation.
REQ-015 SHALL have port i2q2_valid, output, 1: the i2q2_* outputs are valid and stable.
REQ-016 SHALL have ports i2q2_early, i2q2_prompt and i2q2_late, output, I2Q2 width each: I^2+Q^2 of the last accumulation.

Function
REQ-017 Seek: on each cycle with seek_en=1, sample_valid=1 and code_phase!=code_shift, code_phase SHALL advance by +1, wrapping MAX_CODE_SHIFT->0.
REQ-018 seeking and target_reached SHALL be registered, updated every cycle from the post-update values: seeking=seek_en && code_phase!=code_shift; target_reached=(code_phase==code_shift).
REQ-019 Accumulation: six signed accumulators of ACC_WIDTH=CORR_WIDTH+clog2(ACC_LEN)+1 bits plus a sample counter; each sample_valid SHALL add the sign-extended terms and increment the counter; no overflow is possible.
REQ-020 On the sample_valid that makes the count equal ACC_LEN: accumulators SHALL be copied to hold registers, accumulators and counter SHALL clear, and accumulation_complete SHALL pulse high in the next cycle (T).
REQ-021 feed_reset SHALL clear the accumulators and counter with no complete pulse; this applies even if it coincides with the final sample, and feed_reset wins.
REQ-022 Power FSM states SHALL be IDLE -> SQUARE -> DONE.
REQ-023 FSM at T: SHALL leave IDLE, enter SQUARE, drop i2q2_valid and clear the i2q2 sums.
REQ-024 SQUARE SHALL issue one held value per cycle to a single registered squarer over T+1..T+6, order Ie,Qe,Ip,Qp,Il,Ql.
REQ-025 Each square SHALL be added into its i2q2 sum one cycle after issue, over T+2..T+7.
REQ-026 The FSM SHALL enter DONE at T+8 with i2q2_valid=1, holding values until the next accumulation_complete.
REQ-027 The squarer output SHALL be 2*ACC_WIDTH bits; I2Q2 width = 2*ACC_WIDTH+1; no truncation.
REQ-028 If accumulation_complete occurs while the FSM is in SQUARE, the FSM SHALL restart from the new hold values.
REQ-029 Hold registers SHALL NOT change while the FSM is in SQUARE, except per REQ-028.

Reset
REQ-030 Assertion of global_reset_n SHALL asynchronously clear, immediately and including mid-SQUARE: code_phase, accumulators, counter, hold registers and i2q2 sums; seeking, accumulation_complete and i2q2_valid; and return the FSM to IDLE.
REQ-031 During reset target_reached SHALL read 1 only if code_shift==0, since it is computed from cleared state.

Structure
REQ-032 CS width, MAX_CODE_SHIFT, I2Q2 width and FSM state encodings SHALL live in the shared channel/acquisition package header.
REQ-033 The squarer SHALL be a sub-module, acq_squarer: signed in, registered unsigned square out, 1-cycle latency.

Verification
REQ-034 Reset: assert global_reset_n=0 mid-stream -> all outputs 0, FSM IDLE; after release no accumulation_complete until ACC_LEN samples.
REQ-035 Seek: code_phase=0, code_shift=5, seek_en=1 with continuous samples -> seeking for 5 samples, code_phase=5, target_reached=1, seeking=0.
REQ-036 Wrap: code_phase=MAX_CODE_SHIFT, code_shift=1 -> code_phase goes MAX->0->1, then target_reached=1.
REQ-037 Power, with ACC_LEN=16: constant early I=3, Q=-4 (others 0) -> accumulation_complete at T; from T+8 i2q2_valid=1, i2q2_early=48^2+64^2=6400, prompt=late=0.
REQ-038 Collision: feed_reset on the 16th sample -> no accumulation_complete; the next 16 samples give a normal complete.
REQ-039 Reset at T+4 -> i2q2_valid stays 0 and sums are 0.
